// File: rtl/ttl_memory_block_if.sv
// ttl_memory_block_if: request/response handshake bundle for the TTL cache storage array
interface ttl_memory_block_if #(
  parameter int NUM_ENTRIES = 4,
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 8,
  parameter int TTL_WIDTH   = 8
) ();
  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [KEY_WIDTH-1:0]   req_key;
  logic [VALUE_WIDTH-1:0] req_value;
  logic [TTL_WIDTH-1:0]   req_ttl;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [1:0]             resp_status;
  logic [VALUE_WIDTH-1:0] resp_value;
  logic [NUM_ENTRIES-1:0] resp_index;
  modport master (
    output req_valid, req_op, req_key, req_value, req_ttl, resp_ready,
    input  req_ready, resp_valid, resp_status, resp_value, resp_index
  );
  modport slave (
    input  req_valid, req_op, req_key, req_value, req_ttl, resp_ready,
    output req_ready, resp_valid, resp_status, resp_value, resp_index
  );
endinterface

// File: rtl/ttl_memory_block.sv
// ttl_memory_block: key/value/TTL slot array with lookup, allocation, delete and tick-driven expiry
module ttl_memory_block #(
  parameter int NUM_ENTRIES = 4,
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 8,
  parameter int TTL_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ttl_memory_block_if.slave      bus,
  input  logic                   tick,
  output logic [NUM_ENTRIES-1:0] used_entries,
  output logic                   full,
  output logic                   expired
);
  localparam logic [1:0] ST_OK = 2'b00, ST_MISS = 2'b01, ST_FULL = 2'b10, ST_BAD = 2'b11;
  localparam logic [1:0] OP_GET = 2'b00, OP_PUT = 2'b01, OP_DEL = 2'b10;
  typedef enum logic {IDLE, RESP} state_t;
  state_t                 state;
  logic [KEY_WIDTH-1:0]   key_q [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0] val_q [NUM_ENTRIES];
  logic [TTL_WIDTH-1:0]   ttl_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] used_q, match, free, first_free, put_tgt, put_sel, del_sel, exp_v;
  logic [VALUE_WIDTH-1:0] rd_val, nxt_value;
  logic [NUM_ENTRIES-1:0] nxt_index;
  logic [1:0]             nxt_status;
  logic                   accept, bad, hit, is_get, is_put, is_del;
  assign used_entries = used_q;
  assign full         = &used_q;
  assign free         = ~used_q;
  assign first_free   = free & (~free + NUM_ENTRIES'(1));
  assign accept       = (state == IDLE) && bus.req_valid;
  assign bad          = (bus.req_key == '0) || (bus.req_op == 2'b11);
  assign is_get       = bus.req_op == OP_GET;
  assign is_put       = bus.req_op == OP_PUT;
  assign is_del       = bus.req_op == OP_DEL;
  assign hit          = |match;
  assign put_tgt      = hit ? match : first_free;
  assign put_sel      = (accept && !bad && is_put) ? put_tgt : '0;
  assign del_sel      = (accept && !bad && is_del) ? match : '0;
  assign nxt_status   = bad ? ST_BAD : is_put ? ((hit || !full) ? ST_OK : ST_FULL) : (hit ? ST_OK : ST_MISS);
  assign nxt_value    = (!bad && is_get && hit) ? rd_val : '0;
  assign nxt_index    = bad ? '0 : is_put ? put_tgt : match;
  // Key match, read mux and per-slot expiry detection against pre-edge slot state
  always_comb begin
    match  = '0;
    rd_val = '0;
    exp_v  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match[i] = used_q[i] && (key_q[i] == bus.req_key);
      rd_val   = rd_val | (match[i] ? val_q[i] : '0);
      exp_v[i] = tick && used_q[i] && (ttl_q[i] == TTL_WIDTH'(1)) && !put_sel[i] && !del_sel[i];
    end
  end
  // Slot storage: PUT beats DEL beats expiry beats TTL decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        key_q[i] <= '0;
        val_q[i] <= '0;
        ttl_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (put_sel[i]) begin
          key_q[i]  <= bus.req_key;
          val_q[i]  <= bus.req_value;
          ttl_q[i]  <= bus.req_ttl;
          used_q[i] <= 1'b1;
        end else if (del_sel[i] || exp_v[i]) begin
          key_q[i]  <= '0;
          val_q[i]  <= '0;
          ttl_q[i]  <= '0;
          used_q[i] <= 1'b0;
        end else if (tick && used_q[i] && (ttl_q[i] > TTL_WIDTH'(1))) begin
          ttl_q[i] <= ttl_q[i] - TTL_WIDTH'(1);
        end
      end
    end
  end
  // Handshake FSM with registered response and expiry pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_status <= '0;
      bus.resp_value  <= '0;
      bus.resp_index  <= '0;
      expired         <= 1'b0;
    end else begin
      expired <= |exp_v;
      if (state == IDLE && bus.req_valid) begin
        state           <= RESP;
        bus.req_ready   <= 1'b0;
        bus.resp_valid  <= 1'b1;
        bus.resp_status <= nxt_status;
        bus.resp_value  <= nxt_value;
        bus.resp_index  <= nxt_index;
      end else if (state == RESP && bus.resp_ready) begin
        state           <= IDLE;
        bus.req_ready   <= 1'b1;
        bus.resp_valid  <= 1'b0;
        bus.resp_status <= '0;
        bus.resp_value  <= '0;
        bus.resp_index  <= '0;
      end
    end
  end
endmodule
